fibonacci_checker: RTL
======================

FIBONACCI_CHECKER -- requirements
Module: fibonacci_checker

Interface
REQ-001 Parameters: none; the data width is fixed at 8 bits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 clear  input  1  synchronous restart to IDLE; clears counters.
REQ-005 in_valid  input  1  in_data holds a sample this cycle.
REQ-006 in_data  input  8  received sample, an unsigned Fibonacci term mod 256.
REQ-007 locked  output  1  high while the stream is tracking a valid sequence.
REQ-008 err  output  1  one-cycle pulse on a mismatch while locked.
REQ-009 err_count  output  8  total mismatches since reset/clear; saturates at 255.
REQ-010 seq_index  output  8  samples in the current locked run; saturates at 255.
REQ-011 expected  output  8  next term expected from the internal history.

Function
REQ-012 The block SHALL hold two history registers, prev and cur (8 bits each), and an FSM with states IDLE, HAVE1, HAVE2 and LOCKED.
REQ-013 All outputs SHALL be registered; a sample taken at edge N SHALL be reflected on the outputs immediately after edge N.
REQ-014 Cycles with in_valid=0 SHALL change no state, counter or output (err SHALL be 0).
REQ-015 IDLE on a valid sample: cur<=in_data; go to HAVE1.
REQ-016 HAVE1 on a valid sample: prev<=cur, cur<=in_data; go to HAVE2.
REQ-017 The sum prev+cur SHALL be computed mod 256, with the carry discarded; wrap-around is legal and SHALL NOT count as an error.
REQ-018 HAVE2 on a valid sample:
  - if in_data == prev+cur: shift history, go to LOCKED, seq_index<=3.
  - otherwise: shift history, stay in HAVE2.
  - err SHALL NOT assert in HAVE2.
REQ-019 LOCKED on a valid matching sample: shift history; seq_index increments, saturating at 255.
REQ-020 LOCKED on a valid mismatching sample:
  - err=1 for exactly one cycle; err_count increments, saturating at 255.
  - prev<=cur, cur<=in_data; seq_index<=0.
  - go to HAVE2, so the next matching sample relocks the block.
REQ-021 locked SHALL be 1 if and only if the state is LOCKED.
REQ-022 expected SHALL equal (prev+cur) mod 256 in HAVE2 and LOCKED, and 0 in IDLE and HAVE1.
REQ-023 clear=1 SHALL return the block to IDLE, with prev, cur, seq_index, err_count and err all 0.
REQ-024 clear SHALL take priority over a same-cycle in_valid; that sample SHALL be discarded.
REQ-025 The shift on every accepted sample SHALL use pre-edge values: prev<=cur, cur<=in_data.

Reset
REQ-026 reset=1 SHALL immediately (asynchronously) force the following, regardless of clk:
  - state IDLE;
  - prev, cur, seq_index, err_count = 0;
  - err, locked = 0.
REQ-027 Reset asserted mid-run SHALL discard all history; after release, the first valid sample SHALL be treated as a stream start.
REQ-028 Reset SHALL take priority over clear and in_valid.

Verification
REQ-029 Lock: from reset, feed 0,1,1,2,3,5 -> locked=1 after the 3rd sample with seq_index=3; seq_index=6 after 5; expected=8; err never asserts.
REQ-030 Wrap: a locked stream continues 89,144,233,121,98 -> no err; locked stays 1; expected=219 after 98.
REQ-031 Fault/relock: locked after 0,1,1,2,3,5, then feed 7 ->
  - err=1 for one cycle; err_count=1; locked=0; seq_index=0; expected=12;
  - then feed 12 -> locked=1, seq_index=3.
REQ-032 Gaps: a locked stream with in_valid=0 for 5 cycles between terms -> outputs hold; no err; seq_index advances only on valid cycles.
REQ-033 Clear: while locked with err_count=2, assert clear with in_valid=1 and in_data=8 -> next cycle IDLE, locked=0, err_count=0, expected=0.
REQ-034 Async reset: assert reset between clock edges while locked -> locked, seq_index and err_count are 0 before the next edge; after release, 0,1,1 relocks.

Source files
------------

// File: rtl/fibonacci_checker.sv
// Fibonacci stream checker.
// Tracks an 8-bit Fibonacci sequence (mod 256) arriving on in_data. After two
// seed samples, each further sample is compared with the sum of the previous
// two. A match from HAVE2 locks the checker. A mismatch while locked raises a
// one-cycle err pulse and drops back to HAVE2, so the stream can relock.
// All outputs are registers that change on the edge that accepts a sample.
module fibonacci_checker (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       locked,
  output logic       err,
  output logic [7:0] err_count,
  output logic [7:0] seq_index,
  output logic [7:0] expected
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HAVE1  = 2'd1,
    HAVE2  = 2'd2,
    LOCKED = 2'd3
  } state_t;

  state_t     state_r;
  logic [7:0] prev_r;
  logic [7:0] cur_r;

  logic [7:0] sum_s;       // term predicted from the current history
  logic [7:0] next_sum_s;  // term predicted once in_data has been shifted in
  logic       match_s;

  // Increment that sticks at the top of the 8-bit range.
  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    logic [7:0] result;
    if (value == 8'd255) begin
      result = 8'd255;
    end else begin
      result = value + 8'd1;
    end
    return result;
  endfunction

  // Mod-256 sums: the carry is dropped on purpose, so wrap-around is legal.
  always_comb begin
    sum_s      = prev_r + cur_r;
    next_sum_s = cur_r + in_data;
    match_s    = (in_data == sum_s);
  end

  // Sequence-tracking FSM with history, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      prev_r    <= 8'd0;
      cur_r     <= 8'd0;
      locked    <= 1'b0;
      err       <= 1'b0;
      err_count <= 8'd0;
      seq_index <= 8'd0;
      expected  <= 8'd0;
    end else if (clear) begin
      // clear wins over a same-cycle sample, and that sample is dropped.
      state_r   <= IDLE;
      prev_r    <= 8'd0;
      cur_r     <= 8'd0;
      locked    <= 1'b0;
      err       <= 1'b0;
      err_count <= 8'd0;
      seq_index <= 8'd0;
      expected  <= 8'd0;
    end else if (in_valid) begin
      case (state_r)
        IDLE: begin
          // First sample of a new stream: just remember it.
          cur_r    <= in_data;
          state_r  <= HAVE1;
          locked   <= 1'b0;
          err      <= 1'b0;
          expected <= 8'd0;
        end
        HAVE1: begin
          // Second seed sample: from now on a prediction is possible.
          prev_r   <= cur_r;
          cur_r    <= in_data;
          state_r  <= HAVE2;
          locked   <= 1'b0;
          err      <= 1'b0;
          expected <= next_sum_s;
        end
        HAVE2: begin
          // Looking for the first matching term. A mismatch here is not an error.
          prev_r   <= cur_r;
          cur_r    <= in_data;
          err      <= 1'b0;
          expected <= next_sum_s;
          if (match_s) begin
            state_r   <= LOCKED;
            locked    <= 1'b1;
            seq_index <= 8'd3;
          end else begin
            state_r   <= HAVE2;
            locked    <= 1'b0;
          end
        end
        LOCKED: begin
          prev_r   <= cur_r;
          cur_r    <= in_data;
          expected <= next_sum_s;
          if (match_s) begin
            state_r   <= LOCKED;
            locked    <= 1'b1;
            err       <= 1'b0;
            seq_index <= sat_inc(seq_index);
          end else begin
            // Mismatch breaks the run. The bad sample seeds the new history.
            state_r   <= HAVE2;
            locked    <= 1'b0;
            err       <= 1'b1;
            err_count <= sat_inc(err_count);
            seq_index <= 8'd0;
          end
        end
        default: begin
          state_r   <= IDLE;
          prev_r    <= 8'd0;
          cur_r     <= 8'd0;
          locked    <= 1'b0;
          err       <= 1'b0;
          seq_index <= 8'd0;
          expected  <= 8'd0;
        end
      endcase
    end else begin
      // Idle cycle: everything holds, and the err pulse ends.
      err <= 1'b0;
    end
  end

endmodule
